x86_insn_header_parser: RTL and testbench
=========================================

Name: x86_insn_header_parser

Overview:
- Byte-serial front end of the x86-64 decode path, one fetched byte accepted per cycle.
- Strips legacy and REX prefixes, resolves the 0F escape, and captures ModRM, SIB and displacement.
- Emits one instruction-header descriptor per instruction to the downstream opcode-lookup/decode stage.
- ModRM presence comes from the 256-bit ModRM-present maps exported by the opcode table block.

Parameters:
MAX_LEN, 15, architectural instruction length limit in bytes; header parse fails when exceeded.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  in_byte valid
in_ready  out  1  parser accepts in_byte this cycle
in_byte  in  8  next instruction byte
modrm_map1  in  256  one-byte opcode ModRM-present map; opcode N uses bit (255-N)
modrm_map2  in  256  0F-escaped opcode ModRM-present map; same indexing
out_valid  out  1  descriptor valid
out_ready  in  1  downstream accepts descriptor
out_lock  out  1  F0 seen
out_rep  out  2  00 none, 10 F2, 11 F3
out_seg  out  3  0 none, 1 ES(26), 2 CS(2E), 3 SS(36), 4 DS(3E), 5 FS(64), 6 GS(65)
out_opsz  out  1  66 seen
out_adsz  out  1  67 seen
out_rex_present  out  1  REX byte immediately preceded opcode
out_rex  out  4  REX W,R,X,B
out_esc  out  1  opcode is 0F-escaped
out_opcode  out  8  opcode byte (second byte if escaped)
out_has_modrm  out  1  ModRM captured
out_modrm  out  8  ModRM byte
out_has_sib  out  1  SIB captured
out_sib  out  8  SIB byte
out_disp  out  32  displacement, sign-extended to 32 bits
out_len  out  4  header bytes consumed (prefixes through displacement)
out_err  out  1  MAX_LEN exceeded; other fields undefined

Behaviour:
- Reset state:
  - State PREFIX.
  - out_valid=0; all out_* fields 0.
  - Byte counter 0; all prefix accumulators cleared.
  - Reset mid-instruction discards all partial state.
- in_ready = !out_valid || out_ready. A byte is consumed when in_valid && in_ready.
- Descriptor registration:
  - Registered in the cycle the final header byte is consumed.
  - out_valid rises the next cycle.
  - Fields hold stable while out_valid && !out_ready.
  - If a descriptor is accepted and a new byte arrives in the same cycle, both happen: the new byte starts the next instruction.
- State PREFIX (also the opcode position):
  - Legacy prefixes: F0, F2, F3, 26, 2E, 36, 3E, 64, 65, 66, 67.
    - Set their flag and stay in PREFIX.
    - Later F2/F3 overrides earlier out_rep; later segment prefix overrides earlier out_seg.
    - A legacy prefix after a REX byte clears the REX accumulation (REX is ignored unless it is last before the opcode).
  - 40-4F: latch REX bits, set rex_present, stay in PREFIX.
  - 0F: set esc, go to ESC.
  - Any other byte is the opcode.
    - If modrm_map1[255-byte]: go to MODRM.
    - Otherwise: done.
- State ESC: the byte is the opcode.
  - If modrm_map2[255-byte]: go to MODRM.
  - Otherwise: done.
- State MODRM: capture ModRM.
  - mod=11: done.
  - mod!=11 and rm=100: go to SIB.
  - mod=00, rm=101: disp32 (RIP-relative).
  - mod=01: disp8.
  - mod=10: disp32.
  - mod=00, rm!=100/101: done.
- State SIB: capture SIB.
  - Displacement size follows the ModRM mod field (disp8 or disp32).
  - Exception: mod=00 with SIB base=101 gives disp32.
  - Otherwise done.
- State DISP:
  - Little-endian byte collection with a down-counter.
  - disp8 is sign-extended.
  - Done after the last displacement byte.
- 67 does not change ModRM/SIB format; 64-bit addressing form is always used.
- Length and error:
  - Counter increments per consumed byte; out_len = total consumed.
  - If MAX_LEN bytes are consumed without reaching done, emit a descriptor with out_err=1 and out_len=MAX_LEN.
  - Then return to PREFIX; the next byte is parsed as a fresh instruction.
- Immediates are not parsed; the downstream stage consumes them.
- On done, all accumulators clear and the state returns to PREFIX.

Test Plan:
1. 48 89 E5 -> rex_present=1, rex=1000, opcode=89, modrm=E5, has_sib=0, disp=0, len=3, valid one cycle after E5 accepted.
2. 0F B6 45 F8 (map2 bit 255-B6 set) -> esc=1, opcode=B6, modrm=45, disp=FFFFFFF8, len=4.
3. 8B 04 25 78 56 34 12 -> modrm=04, has_sib=1, sib=25, disp=12345678, len=7.
4. F2 F3 2E 64 50 -> rep=11, seg=5, opcode=50, has_modrm=0, len=5. Then 48 66 8B C0 -> rex_present=0, opsz=1, modrm=C0, len=4.
5. Fifteen bytes of 66 -> err=1, len=15 after the 15th byte. The following byte 90 -> opcode=90, len=1, err=0.
6. out_ready=0 for 3 cycles after a descriptor -> in_ready=0, fields stable. Then assert reset_n=0 after 48 8B -> out_valid=0 immediately. After release, C3 parses as opcode=C3, rex_present=0, len=1.

Source files
------------

// File: rtl/x86_insn_header_parser.sv
// Byte-serial x86-64 instruction header parser: strips prefixes, resolves 0F, captures ModRM/SIB/disp
// and hands one descriptor per instruction to the opcode-lookup stage through a valid/ready register.
module x86_insn_header_parser #(
  parameter int MAX_LEN = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic [255:0] modrm_map1,
  input  logic [255:0] modrm_map2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_lock,
  output logic [1:0]   out_rep,
  output logic [2:0]   out_seg,
  output logic         out_opsz,
  output logic         out_adsz,
  output logic         out_rex_present,
  output logic [3:0]   out_rex,
  output logic         out_esc,
  output logic [7:0]   out_opcode,
  output logic         out_has_modrm,
  output logic [7:0]   out_modrm,
  output logic         out_has_sib,
  output logic [7:0]   out_sib,
  output logic [31:0]  out_disp,
  output logic [3:0]   out_len,
  output logic         out_err
);

  localparam logic [3:0] MaxLen = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_PREFIX,
    ST_ESC,
    ST_MODRM,
    ST_SIB,
    ST_DISP
  } state_e;

  typedef struct packed {
    logic        lock;
    logic [1:0]  rep;
    logic [2:0]  seg;
    logic        opsz;
    logic        adsz;
    logic        rexPresent;
    logic [3:0]  rex;
    logic        esc;
    logic [7:0]  opcode;
    logic        hasModrm;
    logic [7:0]  modrm;
    logic        hasSib;
    logic [7:0]  sib;
    logic [31:0] disp;
  } hdr_t;

  state_e     state_q, state_d;
  hdr_t       acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] dispLeft_q, dispLeft_d;
  logic       dispIs8_q, dispIs8_d;
  hdr_t       outHdr_q;
  logic [3:0] outLen_q;
  logic       outErr_q;
  logic       outValid_q;

  logic take;
  logic done;
  logic emit;

  assign in_ready = !outValid_q || out_ready;
  assign take     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dispLeft_d = dispLeft_q;
    dispIs8_d  = dispIs8_q;
    done       = 1'b0;
    if (take) begin
      cnt_d = cnt_q + 4'd1;
      unique case (state_q)
        ST_PREFIX: begin
          // REX only counts when it is the last byte before the opcode
          if (in_byte inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36,
                              8'h3E, 8'h64, 8'h65, 8'h66, 8'h67}) begin
            acc_d.rexPresent = 1'b0;
            acc_d.rex        = 4'd0;
          end
          casez (in_byte)
            8'hF0:        acc_d.lock = 1'b1;
            8'hF2:        acc_d.rep  = 2'b10;
            8'hF3:        acc_d.rep  = 2'b11;
            8'h26:        acc_d.seg  = 3'd1;
            8'h2E:        acc_d.seg  = 3'd2;
            8'h36:        acc_d.seg  = 3'd3;
            8'h3E:        acc_d.seg  = 3'd4;
            8'h64:        acc_d.seg  = 3'd5;
            8'h65:        acc_d.seg  = 3'd6;
            8'h66:        acc_d.opsz = 1'b1;
            8'h67:        acc_d.adsz = 1'b1;
            8'b0100_????: begin
              acc_d.rexPresent = 1'b1;
              acc_d.rex        = in_byte[3:0];
            end
            8'h0F: begin
              acc_d.esc = 1'b1;
              state_d   = ST_ESC;
            end
            default: begin
              acc_d.opcode = in_byte;
              if (modrm_map1[~in_byte]) state_d = ST_MODRM;
              else                      done    = 1'b1;
            end
          endcase
        end
        ST_ESC: begin
          acc_d.opcode = in_byte;
          if (modrm_map2[~in_byte]) state_d = ST_MODRM;
          else                      done    = 1'b1;
        end
        ST_MODRM: begin
          acc_d.modrm    = in_byte;
          acc_d.hasModrm = 1'b1;
          if (in_byte[7:6] == 2'b11) begin
            done = 1'b1;
          end else if (in_byte[2:0] == 3'b100) begin
            state_d = ST_SIB;
          end else if (in_byte[7:6] == 2'b01) begin
            state_d    = ST_DISP;
            dispLeft_d = 3'd1;
            dispIs8_d  = 1'b1;
          end else if (in_byte[7:6] == 2'b10 || in_byte[2:0] == 3'b101) begin
            state_d    = ST_DISP;
            dispLeft_d = 3'd4;
            dispIs8_d  = 1'b0;
          end else begin
            done = 1'b1;
          end
        end
        ST_SIB: begin
          acc_d.sib    = in_byte;
          acc_d.hasSib = 1'b1;
          if (acc_q.modrm[7:6] == 2'b01) begin
            state_d    = ST_DISP;
            dispLeft_d = 3'd1;
            dispIs8_d  = 1'b1;
          end else if (acc_q.modrm[7:6] == 2'b10 || in_byte[2:0] == 3'b101) begin
            state_d    = ST_DISP;
            dispLeft_d = 3'd4;
            dispIs8_d  = 1'b0;
          end else begin
            done = 1'b1;
          end
        end
        ST_DISP: begin
          // disp32 arrives little-endian, so each byte shifts in from the top
          if (dispIs8_q) acc_d.disp = {{24{in_byte[7]}}, in_byte};
          else           acc_d.disp = {in_byte, acc_q.disp[31:8]};
          dispLeft_d = dispLeft_q - 3'd1;
          if (dispLeft_q == 3'd1) done = 1'b1;
        end
        default: state_d = ST_PREFIX;
      endcase
    end
  end

  assign emit = take && (done || cnt_d == MaxLen);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PREFIX;
      acc_q      <= '0;
      cnt_q      <= 4'd0;
      dispLeft_q <= 3'd0;
      dispIs8_q  <= 1'b0;
    end else if (emit) begin
      state_q    <= ST_PREFIX;
      acc_q      <= '0;
      cnt_q      <= 4'd0;
      dispLeft_q <= 3'd0;
      dispIs8_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dispLeft_q <= dispLeft_d;
      dispIs8_q  <= dispIs8_d;
    end
  end

  // Descriptor holds until accepted; a new emit can only occur when the slot is free or draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outHdr_q   <= '0;
      outLen_q   <= 4'd0;
      outErr_q   <= 1'b0;
      outValid_q <= 1'b0;
    end else if (emit) begin
      outHdr_q   <= acc_d;
      outLen_q   <= cnt_d;
      outErr_q   <= !done;
      outValid_q <= 1'b1;
    end else if (outValid_q && out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid       = outValid_q;
  assign out_lock        = outHdr_q.lock;
  assign out_rep         = outHdr_q.rep;
  assign out_seg         = outHdr_q.seg;
  assign out_opsz        = outHdr_q.opsz;
  assign out_adsz        = outHdr_q.adsz;
  assign out_rex_present = outHdr_q.rexPresent;
  assign out_rex         = outHdr_q.rex;
  assign out_esc         = outHdr_q.esc;
  assign out_opcode      = outHdr_q.opcode;
  assign out_has_modrm   = outHdr_q.hasModrm;
  assign out_modrm       = outHdr_q.modrm;
  assign out_has_sib     = outHdr_q.hasSib;
  assign out_sib         = outHdr_q.sib;
  assign out_disp        = outHdr_q.disp;
  assign out_len         = outLen_q;
  assign out_err         = outErr_q;

endmodule

// File: tb/tb_x86_insn_header_parser.sv
// Scoreboard bench for x86_insn_header_parser: a software-style buffer parser predicts each
// descriptor as bytes are issued; a negedge monitor pops and compares on every handshake.
module tb_x86_insn_header_parser;

  localparam int MAX_LEN = 15;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic [255:0] map1, map2;
  logic         out_valid, out_ready;
  logic         out_lock, out_opsz, out_adsz, out_rex_present, out_esc;
  logic         out_has_modrm, out_has_sib, out_err;
  logic [1:0]   out_rep;
  logic [2:0]   out_seg;
  logic [3:0]   out_rex, out_len;
  logic [7:0]   out_opcode, out_modrm, out_sib;
  logic [31:0]  out_disp;

  x86_insn_header_parser #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .modrm_map1(map1), .modrm_map2(map2), .out_valid(out_valid), .out_ready(out_ready),
    .out_lock(out_lock), .out_rep(out_rep), .out_seg(out_seg), .out_opsz(out_opsz),
    .out_adsz(out_adsz), .out_rex_present(out_rex_present), .out_rex(out_rex),
    .out_esc(out_esc), .out_opcode(out_opcode), .out_has_modrm(out_has_modrm),
    .out_modrm(out_modrm), .out_has_sib(out_has_sib), .out_sib(out_sib),
    .out_disp(out_disp), .out_len(out_len), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lock;
    logic [1:0]  rep;
    logic [2:0]  seg;
    logic        opsz, adsz, rexPresent;
    logic [3:0]  rex;
    logic        esc;
    logic [7:0]  opcode;
    logic        hasModrm;
    logic [7:0]  modrm;
    logic        hasSib;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [3:0]  len;
    logic        err;
  } desc_t;

  desc_t      expQ[$];
  logic [7:0] modelBuf[$];
  int         checks = 0;
  int         failures = 0;
  int         readyMode = 1;
  logic [7:0] legacyTab [11] = '{8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36,
                                 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = byte available, 1 = buffer exhausted, 2 = length limit reached
  function automatic int fetch(input int i, output logic [7:0] b);
    b = 8'h00;
    if (i >= MAX_LEN) return 2;
    if (i >= modelBuf.size()) return 1;
    b = modelBuf[i];
    return 0;
  endfunction

  function automatic bit giveUp(input int st, output desc_t d, output int used);
    d = '{default: '0};
    used = 0;
    if (st == 1) return 1'b0;
    d.err = 1'b1;
    d.len = 4'(MAX_LEN);
    used = MAX_LEN;
    return 1'b1;
  endfunction

  function automatic bit tryDecode(output desc_t d, output int used);
    logic [7:0] b;
    int i = 0;
    int st;
    int nDisp = 0;
    d = '{default: '0};
    used = 0;
    while (1'b1) begin
      st = fetch(i, b);
      if (st != 0) return giveUp(st, d, used);
      i++;
      if (b == 8'h0F) begin
        d.esc = 1'b1;
        st = fetch(i, b);
        if (st != 0) return giveUp(st, d, used);
        i++;
        d.opcode = b;
        break;
      end else if (b inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67}) begin
        d.rexPresent = 1'b0;
        d.rex = 4'd0;
        case (b)
          8'hF0: d.lock = 1'b1;
          8'hF2: d.rep = 2'b10;
          8'hF3: d.rep = 2'b11;
          8'h26: d.seg = 3'd1;
          8'h2E: d.seg = 3'd2;
          8'h36: d.seg = 3'd3;
          8'h3E: d.seg = 3'd4;
          8'h64: d.seg = 3'd5;
          8'h65: d.seg = 3'd6;
          8'h66: d.opsz = 1'b1;
          default: d.adsz = 1'b1;
        endcase
      end else if (b >= 8'h40 && b <= 8'h4F) begin
        d.rexPresent = 1'b1;
        d.rex = b[3:0];
      end else begin
        d.opcode = b;
        break;
      end
    end
    d.hasModrm = d.esc ? map2[255 - int'(d.opcode)] : map1[255 - int'(d.opcode)];
    if (d.hasModrm) begin
      st = fetch(i, b);
      if (st != 0) return giveUp(st, d, used);
      i++;
      d.modrm = b;
      if (d.modrm[7:6] != 2'b11) begin
        if (d.modrm[2:0] == 3'd4) begin
          st = fetch(i, b);
          if (st != 0) return giveUp(st, d, used);
          i++;
          d.hasSib = 1'b1;
          d.sib = b;
        end
        if (d.modrm[7:6] == 2'b01) nDisp = 1;
        else if (d.modrm[7:6] == 2'b10) nDisp = 4;
        else if (!d.hasSib && d.modrm[2:0] == 3'd5) nDisp = 4;
        else if (d.hasSib && d.sib[2:0] == 3'd5) nDisp = 4;
        for (int k = 0; k < nDisp; k++) begin
          st = fetch(i, b);
          if (st != 0) return giveUp(st, d, used);
          i++;
          d.disp = d.disp | (32'(b) << (8 * k));
        end
        if (nDisp == 1) d.disp = 32'($signed(d.disp[7:0]));
      end
    end
    d.len = 4'(i);
    used = i;
    return 1'b1;
  endfunction

  task automatic runModel();
    desc_t d;
    int used;
    while (tryDecode(d, used)) begin
      expQ.push_back(d);
      repeat (used) void'(modelBuf.pop_front());
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_byte  = b;
    modelBuf.push_back(b);
    runModel();
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    desc_t e;
    if (reset_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_descriptor: got opcode %0h expected none", out_opcode);
      end else begin
        e = expQ.pop_front();
        checkOutput("err", 32'(out_err), 32'(e.err));
        checkOutput("len", 32'(out_len), 32'(e.len));
        if (!e.err) begin
          checkOutput("lock",     32'(out_lock),        32'(e.lock));
          checkOutput("rep",      32'(out_rep),         32'(e.rep));
          checkOutput("seg",      32'(out_seg),         32'(e.seg));
          checkOutput("opsz",     32'(out_opsz),        32'(e.opsz));
          checkOutput("adsz",     32'(out_adsz),        32'(e.adsz));
          checkOutput("rex_pres", 32'(out_rex_present), 32'(e.rexPresent));
          checkOutput("rex",      32'(out_rex),         32'(e.rex));
          checkOutput("esc",      32'(out_esc),         32'(e.esc));
          checkOutput("opcode",   32'(out_opcode),      32'(e.opcode));
          checkOutput("has_modrm",32'(out_has_modrm),   32'(e.hasModrm));
          checkOutput("modrm",    32'(out_modrm),       32'(e.modrm));
          checkOutput("has_sib",  32'(out_has_sib),     32'(e.hasSib));
          checkOutput("sib",      32'(out_sib),         32'(e.sib));
          checkOutput("disp",     out_disp,             e.disp);
        end
      end
    end
  end

  task automatic drain();
    int guard = 0;
    readyMode = 1;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expQ.size());
    end
  endtask

  initial begin
    logic [7:0] b;
    int n;
    int guard;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      map1[w*32 +: 32] = $urandom;
      map2[w*32 +: 32] = $urandom;
    end
    map1[255 - 8'h89] = 1'b1;
    map1[255 - 8'h8B] = 1'b1;
    map1[255 - 8'h50] = 1'b0;
    map1[255 - 8'h90] = 1'b0;
    map1[255 - 8'hC3] = 1'b0;
    map2[255 - 8'hB6] = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_valid",  32'(out_valid),  32'd0);
    checkOutput("reset_len",    32'(out_len),    32'd0);
    checkOutput("reset_opcode", 32'(out_opcode), 32'd0);
    checkOutput("reset_ready",  32'(in_ready),   32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // 48 89 E5
    applyStimulus(8'h48);
    applyStimulus(8'h89);
    checkOutput("t1_valid_early", 32'(out_valid), 32'd0);
    applyStimulus(8'hE5);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_rex",   32'(out_rex),   32'h8);
    checkOutput("t1_len",   32'(out_len),   32'd3);

    // 0F B6 45 F8
    applyStimulus(8'h0F); applyStimulus(8'hB6); applyStimulus(8'h45); applyStimulus(8'hF8);
    checkOutput("t2_disp", out_disp, 32'hFFFF_FFF8);
    checkOutput("t2_esc",  32'(out_esc), 32'd1);

    // 8B 04 25 78 56 34 12
    applyStimulus(8'h8B); applyStimulus(8'h04); applyStimulus(8'h25);
    applyStimulus(8'h78); applyStimulus(8'h56); applyStimulus(8'h34); applyStimulus(8'h12);
    checkOutput("t3_disp", out_disp, 32'h1234_5678);
    checkOutput("t3_len",  32'(out_len), 32'd7);

    // F2 F3 2E 64 50, then 48 66 8B C0
    applyStimulus(8'hF2); applyStimulus(8'hF3); applyStimulus(8'h2E);
    applyStimulus(8'h64); applyStimulus(8'h50);
    checkOutput("t4_rep", 32'(out_rep), 32'h3);
    checkOutput("t4_seg", 32'(out_seg), 32'd5);
    applyStimulus(8'h48); applyStimulus(8'h66); applyStimulus(8'h8B); applyStimulus(8'hC0);
    checkOutput("t4_rex_pres", 32'(out_rex_present), 32'd0);
    checkOutput("t4_len",      32'(out_len),         32'd4);

    // fifteen 66 prefixes overflow the length limit, then 90
    repeat (15) applyStimulus(8'h66);
    checkOutput("t5_err",  32'(out_err), 32'd1);
    checkOutput("t5_len",  32'(out_len), 32'd15);
    applyStimulus(8'h90);
    checkOutput("t5_err2", 32'(out_err),    32'd0);
    checkOutput("t5_op",   32'(out_opcode), 32'h90);
    drain();

    // downstream stall holds the descriptor and blocks input
    readyMode = 2;
    @(negedge clk);
    applyStimulus(8'h90);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t6_stall_valid", 32'(out_valid),  32'd1);
      checkOutput("t6_stall_ready", 32'(in_ready),   32'd0);
      checkOutput("t6_stall_op",    32'(out_opcode), 32'h90);
      @(negedge clk);
    end
    drain();

    // reset mid-instruction discards partial state
    applyStimulus(8'h48);
    applyStimulus(8'h8B);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid",  32'(out_valid),  32'd0);
    checkOutput("t6_rst_opcode", 32'(out_opcode), 32'd0);
    modelBuf.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'hC3);
    checkOutput("t6_op",       32'(out_opcode),      32'hC3);
    checkOutput("t6_rex_pres", 32'(out_rex_present), 32'd0);
    checkOutput("t6_len",      32'(out_len),         32'd1);
    drain();

    // randomized instruction stream with random backpressure and input gaps
    readyMode = 0;
    for (int t = 0; t < 150; t++) begin
      n = ($urandom_range(0, 11) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(0, 11) == 11) applyStimulus(8'h40 | 8'($urandom_range(0, 15)));
        else                             applyStimulus(legacyTab[$urandom_range(0, 10)]);
      end
      if ($urandom_range(0, 3) == 0) applyStimulus(8'h0F);
      do b = 8'($urandom);
      while (b == 8'h0F || (b >= 8'h40 && b <= 8'h4F) ||
             b inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67});
      applyStimulus(b);
      guard = 0;
      while (modelBuf.size() != 0 && guard < 20) begin
        applyStimulus(8'($urandom));
        guard++;
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    guard = 0;
    while (modelBuf.size() != 0 && guard < 20) begin
      applyStimulus(8'h90);
      guard++;
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
